regfile_mp_scoreboard: RTL and testbench

- Parametrised multi-port integer register file for the next-generation RISC-V core; it replaces the single-write, two-read register file.
- Adds configurable read and write port counts, optional write-to-read bypass, an optional hardwired-zero register, and a per-register busy scoreboard.
- Issue logic marks destination registers busy. Writeback clears them.
- Sits between decode/issue (read ports, issue port) and the writeback stage (write ports).

---
 rtl/core_pkg.sv | 12 +
 rtl/regfile_scoreboard_bits.sv | 52 +++++
 rtl/regfile_mp_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_mp_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: default datapath sizes and register-address type.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy flags: issue sets, writeback clears, set wins on collision.
module regfile_scoreboard_bits
  import core_pkg::*;
#(
  parameter int unsigned NREG     = core_pkg::NREG,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREG-1:0]   busy,
  output logic [AW:0]       busy_cnt
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;

  // Clears are applied before the set so a new producer supersedes writeback.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[ZA] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = core_pkg::XLEN,
  parameter int unsigned NREG     = core_pkg::NREG,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];
  logic [NWR-1:0]  wr_ok;
  logic [NREG-1:0] busy;

  // Unpack write ports; writes to the hardwired zero register are dropped here.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j]    = wr_addr[j*AW +: AW];
      wd[j]    = wr_data[j*XLEN +: XLEN];
      wr_ok[j] = wr_en[j] && !(ZERO_REG && (wa[j] == ZA));
    end
  end

  // Ascending loop lets the highest-indexed port win an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) regs[wa[j]] <= wd[j];
      end
    end
  end

  // Bypass is suppressed during reset so every port reads zero immediately.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      d  = regs[ra];
      b  = busy[ra];
      if (BYPASS && !rst) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wa[j] == ra)) begin
            d = wd[j];
            b = 1'b0;
          end
        end
      end
      if (ZERO_REG && (ra == ZA)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[k*XLEN +: XLEN] = d;
      rd_busy[k]              = b;
    end
  end

  regfile_scoreboard_bits #(
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard-driven bench for regfile_mp_scoreboard in its default configuration.
module tb_regfile_mp_scoreboard;

  localparam int XW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*AW-1:0] rd_addr;
  logic [2*XW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XW-1:0] wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [AW:0]     busy_cnt;

  int total = 0;
  int bad   = 0;

  logic [XW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;

  logic [2*XW-1:0] q_data [$];
  logic [1:0]      q_rb   [$];
  logic [AW:0]     q_cnt  [$];

  typedef struct {
    logic [1:0] we;
    int a0; logic [XW-1:0] d0;
    int a1; logic [XW-1:0] d1;
    logic ie; int ia;
    int r0; int r1;
  } step_t;

  always #5 clk = ~clk;

  regfile_mp_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  task automatic drive(input step_t s);
    wr_en    = s.we;
    wr_addr  = {AW'(s.a1), AW'(s.a0)};
    wr_data  = {s.d1, s.d0};
    iss_en   = s.ie;
    iss_addr = AW'(s.ia);
    rd_addr  = {AW'(s.r1), AW'(s.r0)};
  endtask

  function automatic logic [XW-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    logic [XW-1:0] d;
    a = rd_addr[k*AW +: AW];
    d = m_regs[a];
    for (int j = 0; j < 2; j++)
      if (!rst && wr_en[j] && wr_addr[j*AW +: AW] == a) d = wr_data[j*XW +: XW];
    if (a == 0) d = '0;
    return d;
  endfunction

  function automatic logic exp_rb(input int k);
    logic [AW-1:0] a;
    logic b;
    a = rd_addr[k*AW +: AW];
    b = m_busy[a];
    for (int j = 0; j < 2; j++)
      if (!rst && wr_en[j] && wr_addr[j*AW +: AW] == a) b = 1'b0;
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  function automatic logic [NR-1:0] next_busy();
    logic [NR-1:0] nb;
    nb = m_busy;
    for (int j = 0; j < 2; j++)
      if (wr_en[j]) nb[wr_addr[j*AW +: AW]] = 1'b0;
    if (iss_en) nb[iss_addr] = 1'b1;
    nb[0] = 1'b0;
    return nb;
  endfunction

  task automatic push_exp();
    q_data.push_back({exp_rd(1), exp_rd(0)});
    q_rb.push_back({exp_rb(1), exp_rb(0)});
    q_cnt.push_back((AW+1)'($countones(next_busy())));
  endtask

  task automatic advance();
    @(posedge clk);
    m_busy = next_busy();
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XW +: XW];
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('{2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 9});
    model_reset();
    #3;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (rd_busy !== '0) begin bad++; $display("FAIL reset_rd_busy got=%b want=0", rd_busy); end
    total++; if (busy_cnt !== '0) begin bad++; $display("FAIL reset_busy_cnt got=%0d want=0", busy_cnt); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_conflict();
    step_t s[2];
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    s[0] = '{2'b11, 5, 32'h1111, 5, 32'h2222, 1'b0, 0, 5, 5};
    s[1] = '{2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 1};
    for (int i = 0; i < 2; i++) begin
      drive(s[i]); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL conflict_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL conflict_rd_busy step=%0d got=%b want=%b", i, rd_busy, eb); end
      if (i == 1) begin
        total++; if (rd_data[XW-1:0] !== 32'h0000_2222) begin bad++; $display("FAIL conflict_x5 got=%h want=00002222", rd_data[XW-1:0]); end
      end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec) begin bad++; $display("FAIL conflict_busy_cnt step=%0d got=%0d want=%0d", i, busy_cnt, ec); end
    end
  endtask

  task automatic test_bypass();
    step_t s[3];
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    s[0] = '{2'b01, 7, 32'h0000_0011, 0, 0, 1'b0, 0, 7, 6};
    s[1] = '{2'b10, 0, 0, 7, 32'hDEAD_BEEF, 1'b0, 0, 7, 7};
    s[2] = '{2'b00, 0, 0, 0, 0, 1'b0, 0, 6, 7};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL bypass_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL bypass_rd_busy step=%0d got=%b want=%b", i, rd_busy, eb); end
      if (i == 1) begin
        total++; if (rd_data[XW-1:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_same_cycle got=%h want=deadbeef", rd_data[XW-1:0]); end
      end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec) begin bad++; $display("FAIL bypass_busy_cnt step=%0d got=%0d want=%0d", i, busy_cnt, ec); end
    end
  endtask

  task automatic test_zero_reg();
    step_t s[2];
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    s[0] = '{2'b11, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0};
    s[1] = '{2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 5};
    for (int i = 0; i < 2; i++) begin
      drive(s[i]); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL zero_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL zero_rd_busy step=%0d got=%b want=%b", i, rd_busy, eb); end
      total++; if (rd_data[XW-1:0] !== '0) begin bad++; $display("FAIL zero_x0 step=%0d got=%h want=0", i, rd_data[XW-1:0]); end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec || busy_cnt !== '0) begin bad++; $display("FAIL zero_busy_cnt step=%0d got=%0d want=%0d", i, busy_cnt, ec); end
    end
  endtask

  task automatic test_scoreboard();
    step_t s[3];
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    logic [1:0] lit_rb [3];
    logic [AW:0] lit_cnt [3];
    s[0] = '{2'b00, 0, 0, 0, 0, 1'b1, 3, 3, 4};
    s[1] = '{2'b00, 0, 0, 0, 0, 1'b1, 4, 3, 4};
    s[2] = '{2'b01, 3, 32'h33, 0, 0, 1'b0, 0, 3, 4};
    lit_rb  = '{2'b00, 2'b01, 2'b10};
    lit_cnt = '{6'd1, 6'd2, 6'd1};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL sb_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb || rd_busy !== lit_rb[i]) begin bad++; $display("FAIL sb_rd_busy step=%0d got=%b want=%b", i, rd_busy, lit_rb[i]); end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec || busy_cnt !== lit_cnt[i]) begin bad++; $display("FAIL sb_busy_cnt step=%0d got=%0d want=%0d", i, busy_cnt, lit_cnt[i]); end
    end
  endtask

  task automatic test_set_clear();
    step_t s[3];
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    s[0] = '{2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 4};
    s[1] = '{2'b01, 9, 32'h99, 0, 0, 1'b1, 9, 9, 4};
    s[2] = '{2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 4};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL setclr_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL setclr_rd_busy step=%0d got=%b want=%b", i, rd_busy, eb); end
      if (i == 2) begin
        total++; if (rd_busy[0] !== 1'b1 || rd_data[XW-1:0] !== 32'h99) begin bad++; $display("FAIL setclr_x9 got busy=%b data=%h want busy=1 data=99", rd_busy[0], rd_data[XW-1:0]); end
      end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec || busy_cnt !== 6'd2) begin bad++; $display("FAIL setclr_busy_cnt step=%0d got=%0d want=2", i, busy_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    logic [2*XW-1:0] ed; logic [1:0] eb; logic [AW:0] ec;
    for (int i = 0; i < 60; i++) begin
      s = '{2'($urandom_range(3)), int'($urandom_range(15)), $urandom, int'($urandom_range(15)), $urandom,
            1'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15))};
      drive(s); push_exp();
      @(negedge clk);
      ed = q_data.pop_front(); eb = q_rb.pop_front();
      total++; if (rd_data !== ed) begin bad++; $display("FAIL b2b_rd_data step=%0d got=%h want=%h", i, rd_data, ed); end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL b2b_rd_busy step=%0d got=%b want=%b", i, rd_busy, eb); end
      advance();
      ec = q_cnt.pop_front();
      total++; if (busy_cnt !== ec) begin bad++; $display("FAIL b2b_busy_cnt step=%0d got=%0d want=%0d", i, busy_cnt, ec); end
    end
  endtask

  task automatic test_reset_mid();
    drive('{2'b11, 11, 32'h5555, 12, 32'h6666, 1'b1, 13, 11, 12});
    #2 rst = 1'b1;
    #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL midrst_rd_data got=%h want=0", rd_data); end
    total++; if (rd_busy !== '0) begin bad++; $display("FAIL midrst_rd_busy got=%b want=0", rd_busy); end
    total++; if (busy_cnt !== '0) begin bad++; $display("FAIL midrst_busy_cnt got=%0d want=0", busy_cnt); end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    drive('{2'b00, 0, 0, 0, 0, 1'b0, 0, 11, 13});
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (rd_data !== '0 || rd_busy !== '0 || busy_cnt !== '0) begin
      bad++; $display("FAIL midrst_after got data=%h busy=%b cnt=%0d want 0/0/0", rd_data, rd_busy, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_conflict();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_clear();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
